pipeline_hazard_ctrl: RTL

Hazard and flow-control unit for the 3-stage IF / DE (decode+execute) / MW (memory+writeback) pipeline.
- Consumes the MW-stage control bits registered by the pipeline control register.
- Generates the `stall` that freezes that register and the IF/DE register.
- Generates the DE/MW flush (bubble) requests, the MW→DE operand forwarding selects, and trap/mret redirect pulses.
- Contains a small FSM for multi-cycle data-memory waits with timeout, and a trap-redirect bubble.

---
 rtl/pipeline_hazard_ctrl_if.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 46 ++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-unit bundle between the pipeline and its hazard/flow controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] rs1_D, rs2_D, rd_MW;
  logic rs1_used_D, rs2_used_D, br_taken;
  logic reg_wrMW, rd_enMW, wr_enMW;
  logic csr_reg_rdMW, csr_reg_wrMW, is_mretMW;
  logic [1:0] wb_selMW;
  logic mem_ack, irq_pending;
  logic stall, flush_DE, flush_MW, fwd_a, fwd_b;
  logic trap_take, mret_take, mem_err;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output rs1_D, rs2_D, rd_MW, rs1_used_D, rs2_used_D, br_taken,
           reg_wrMW, rd_enMW, wr_enMW, csr_reg_rdMW, csr_reg_wrMW, is_mretMW,
           wb_selMW, mem_ack, irq_pending,
    input  stall, flush_DE, flush_MW, fwd_a, fwd_b, trap_take, mret_take, mem_err, stall_count
  );
  modport slave (
    input  rs1_D, rs2_D, rd_MW, rs1_used_D, rs2_used_D, br_taken,
           reg_wrMW, rd_enMW, wr_enMW, csr_reg_rdMW, csr_reg_wrMW, is_mretMW,
           wb_selMW, mem_ack, irq_pending,
    output stall, flush_DE, flush_MW, fwd_a, fwd_b, trap_take, mret_take, mem_err, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, flush, forwarding and trap/mret redirect control for a 3-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave h
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
  state_t st;
  logic [7:0] wcnt;
  logic [CNT_W-1:0] cnt;
  logic memop, run, wt, redir, mem_stall, tmo, ev, unused_ok;
  assign memop = h.rd_enMW | h.wr_enMW;
  assign run = st == RUN;
  assign wt = st == MEM_WAIT;
  assign redir = st == REDIRECT;
  assign mem_stall = run & memop & ~h.mem_ack;
  assign tmo = wt & ~h.mem_ack & (wcnt == TMO);
  assign ev = run & ~mem_stall;
  assign h.stall = ~rst & (mem_stall | (wt & ~h.mem_ack & ~tmo));
  assign h.mret_take = ~rst & ev & h.is_mretMW;
  assign h.trap_take = ~rst & ev & ~h.is_mretMW & h.irq_pending;
  assign h.flush_DE = rst | redir | (ev & (h.is_mretMW | h.irq_pending | h.br_taken));
  assign h.flush_MW = rst | redir | tmo;
  assign h.mem_err = ~rst & tmo;
  assign h.fwd_a = ~rst & h.reg_wrMW & (h.rd_MW != 5'd0) & h.rs1_used_D & (h.rs1_D == h.rd_MW);
  assign h.fwd_b = ~rst & h.reg_wrMW & (h.rd_MW != 5'd0) & h.rs2_used_D & (h.rs2_D == h.rd_MW);
  assign h.stall_count = cnt;
  assign unused_ok = ^{h.wb_selMW, h.csr_reg_rdMW, h.csr_reg_wrMW};
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= RUN;
      wcnt <= 8'd0;
      cnt <= '0;
    end else begin
      st <= mem_stall ? MEM_WAIT :
            (h.mret_take | h.trap_take) ? REDIRECT :
            (wt & ~h.mem_ack & ~tmo) ? MEM_WAIT : RUN;
      wcnt <= mem_stall ? 8'd1 : wcnt + 8'(wt);
      cnt <= cnt + CNT_W'(h.stall);
    end
  end
endmodule
